binary_round_ctrl: RTL and testbench
====================================

Name: binary_round_ctrl

Overview:
- Round sequencer for the BinaryMadness game top level.
- Each round it draws a pseudo-random target value, runs a per-round countdown, and judges the player's switch setting when submit is pressed.
- Maintains score and lives, and asserts game_over when lives reach zero.
- The display, debouncers and the 1 Hz tick divider sit outside this block and feed it.

Parameters:
WIDTH, 8, number of player switches and target width
ROUND_TIME, 10, seconds per round, 1..15
LIVES, 3, lives at game start, 1..3
SCORE_W, 8, score register width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle pulse, once per second
start  in  1  debounced one-cycle pulse; begins a game
submit  in  1  debounced one-cycle pulse; player commits answer
sw  in  WIDTH  player switch value
target  out  WIDTH  current round's value to display
time_left  out  4  seconds remaining in current round
score  out  SCORE_W  correct answers this game
lives  out  2  remaining lives
correct_pulse  out  1  one-cycle pulse on correct answer
wrong_pulse  out  1  one-cycle pulse on wrong answer or timeout
game_over  out  1  high while in OVER state
state  out  2  IDLE=0, LOAD=1, PLAY=2, OVER=3

Behaviour:
- One clock and one reset: clk, rst. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state=IDLE, target=0, time_left=ROUND_TIME, score=0, lives=LIVES.
  - correct_pulse=0, wrong_pulse=0, game_over=0.
  - LFSR=16'hACE1.
- rst mid-game aborts immediately to the reset values; no pulse is emitted.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clock in every state except reset.
- IDLE:
  - start -> LOAD; score cleared to 0, lives set to LIVES.
  - submit and tick are ignored.
- LOAD (exactly one cycle):
  - target <= LFSR[WIDTH-1:0]; if that value is 0, target <= 1.
  - time_left <= ROUND_TIME.
  - -> PLAY.
- PLAY:
  - start is ignored.
  - submit has priority over tick in the same cycle; that tick is dropped.
  - submit with sw==target:
    - correct_pulse=1 next cycle.
    - score+1, saturating at all-ones.
    - -> LOAD.
  - submit with sw!=target: wrong_pulse=1 next cycle; lives-1.
  - tick with time_left>1: time_left-1.
  - tick with time_left==1: time_left <= 0, wrong_pulse=1, lives-1 (timeout).
  - After any wrong or timeout: if lives was 1, -> OVER (lives=0); else -> LOAD.
- OVER:
  - game_over=1; score and target hold.
  - start -> LOAD with score=0 and lives=LIVES; game_over clears on the same edge.
- Latency:
  - submit at edge N -> pulse and score/lives update visible after edge N+1.
  - New target visible after edge N+2.
- Pulses are exactly one cycle wide and never asserted together.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined:
  - A 2-bit streak counter increments on each correct answer.
  - The third consecutive correct answer adds 2 instead of 1 (still saturating), then the streak clears.
  - Any wrong answer or timeout clears the streak; reset and start also clear it.
- Undefined: every correct answer adds exactly 1; no streak logic is synthesized.

Test Plan:
- Reset then release -> state=0, score=0, lives=3, time_left=10, target=0, game_over=0; LFSR seed yields a nonzero target after start.
- start, then submit with sw=target -> correct_pulse for 1 cycle, score=1, new target loaded 2 cycles after submit, time_left=10.
- start, then submit with sw=target^1 three times -> wrong_pulse ×3, lives 3->2->1->0, state=3, game_over=1; further submits are ignored.
- start, then 10 ticks with no submit -> time_left 10->1->0, wrong_pulse, lives=2, state LOAD then PLAY, time_left=10.
- submit (correct) and tick in the same cycle with time_left=1 -> correct_pulse only, no lives change, score+1; rst asserted mid-PLAY -> all reset values next cycle.
- STREAK_BONUS_EN defined: 3 correct answers -> score 1,2,4; a 4th correct gives 5; a wrong answer then 3 correct answers -> score +1,+1,+2.

Source files
------------

// File: rtl/binary_round_ctrl.sv
// Round sequencer for BinaryMadness: draws LFSR targets, runs the per-round countdown,
// and judges submissions. The optional streak bonus is enabled by defining STREAK_BONUS_EN.
module binary_round_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ROUND_TIME = 10,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               submit,
  input  logic [WIDTH-1:0]   sw,
  output logic [WIDTH-1:0]   target,
  output logic [3:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               correct_pulse,
  output logic               wrong_pulse,
  output logic               game_over,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [3:0]  RT        = 4'(ROUND_TIME);
  localparam logic [1:0]  LV        = 2'(LIVES);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_t               cur, nxt;
  logic [15:0]          lfsr;
  logic [WIDTH-1:0]     target_n;
  logic [3:0]           time_n;
  logic [SCORE_W-1:0]   score_n;
  logic [1:0]           lives_n;
  logic                 cp_n, wp_n, lose;
  logic [1:0]           inc;
`ifdef STREAK_BONUS_EN
  logic [1:0]           streak, streak_n;
`endif

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-1){1'b0}}, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur           <= IDLE;
      lfsr          <= LFSR_SEED;
      target        <= '0;
      time_left     <= RT;
      score         <= '0;
      lives         <= LV;
      correct_pulse <= 1'b0;
      wrong_pulse   <= 1'b0;
      game_over     <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak        <= '0;
`endif
    end else begin
      cur           <= nxt;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      target        <= target_n;
      time_left     <= time_n;
      score         <= score_n;
      lives         <= lives_n;
      correct_pulse <= cp_n;
      wrong_pulse   <= wp_n;
      game_over     <= (nxt == OVER);
`ifdef STREAK_BONUS_EN
      streak        <= streak_n;
`endif
    end
  end

  always_comb begin
    nxt      = cur;
    target_n = target;
    time_n   = time_left;
    score_n  = score;
    lives_n  = lives;
    cp_n     = 1'b0;
    wp_n     = 1'b0;
    lose     = 1'b0;
`ifdef STREAK_BONUS_EN
    streak_n = streak;
    inc      = (streak == 2'd2) ? 2'd2 : 2'd1;
`else
    inc      = 2'd1;
`endif

    case (cur)
      IDLE, OVER: begin
        if (start) begin
          score_n = '0;
          lives_n = LV;
          nxt     = LOAD;
`ifdef STREAK_BONUS_EN
          streak_n = '0;
`endif
        end
      end
      LOAD: begin
        target_n = (lfsr[WIDTH-1:0] == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : lfsr[WIDTH-1:0];
        time_n   = RT;
        nxt      = PLAY;
      end
      PLAY: begin
        // submit wins over a coincident tick; that tick is simply lost
        if (submit) begin
          if (sw == target) begin
            cp_n    = 1'b1;
            score_n = sat_add(score, inc);
            nxt     = LOAD;
`ifdef STREAK_BONUS_EN
            streak_n = (streak == 2'd2) ? 2'd0 : streak + 2'd1;
`endif
          end else begin
            lose = 1'b1;
          end
        end else if (tick) begin
          if (time_left > 4'd1) begin
            time_n = time_left - 4'd1;
          end else begin
            time_n = '0;
            lose   = 1'b1;
          end
        end
        if (lose) begin
          wp_n    = 1'b1;
          lives_n = lives - 2'd1;
          nxt     = (lives == 2'd1) ? OVER : LOAD;
`ifdef STREAK_BONUS_EN
          streak_n = '0;
`endif
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_binary_round_ctrl.sv
// Randomized self-checking bench for binary_round_ctrl against a game-rule reference model.
// Honours STREAK_BONUS_EN in the model when the same define is given to the bench.
module tb_binary_round_ctrl;

  localparam int WIDTH      = 8;
  localparam int ROUND_TIME = 10;
  localparam int LIVES      = 3;
  localparam int SCORE_W    = 8;

  logic               clk = 1'b0;
  logic               rst, tick, start, submit;
  logic [WIDTH-1:0]   sw;
  logic [WIDTH-1:0]   target;
  logic [3:0]         time_left;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               correct_pulse, wrong_pulse, game_over;
  logic [1:0]         state;

  binary_round_ctrl #(
    .WIDTH      (WIDTH),
    .ROUND_TIME (ROUND_TIME),
    .LIVES      (LIVES),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .start         (start),
    .submit        (submit),
    .sw            (sw),
    .target        (target),
    .time_left     (time_left),
    .score         (score),
    .lives         (lives),
    .correct_pulse (correct_pulse),
    .wrong_pulse   (wrong_pulse),
    .game_over     (game_over),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the game: phase 0 idle, 1 drawing a target, 2 playing, 3 game over
  int          m_phase, m_target, m_time, m_score, m_lives, m_cp, m_wp, m_go, m_streak;
  int unsigned m_lfsr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic new_game();
    m_score  = 0;
    m_lives  = LIVES;
    m_streak = 0;
    m_phase  = 1;
  endtask

  task automatic model_step();
    int unsigned drawn;
    int          gain, max_score;
    max_score = (1 << SCORE_W) - 1;
    if (rst) begin
      m_phase = 0; m_target = 0; m_time = ROUND_TIME; m_score = 0; m_lives = LIVES;
      m_cp = 0; m_wp = 0; m_go = 0; m_streak = 0; m_lfsr = 32'hACE1;
      return;
    end
    drawn  = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_cp = 0;
    m_wp = 0;
    case (m_phase)
      0, 3: if (start) new_game();
      1: begin
        m_target = int'(drawn) & ((1 << WIDTH) - 1);
        if (m_target == 0) m_target = 1;
        m_time  = ROUND_TIME;
        m_phase = 2;
      end
      default: begin
        if (submit && int'(sw) == m_target) begin
          gain = 1;
`ifdef STREAK_BONUS_EN
          m_streak++;
          if (m_streak == 3) begin gain = 2; m_streak = 0; end
`endif
          m_score = (m_score + gain > max_score) ? max_score : m_score + gain;
          m_cp    = 1;
          m_phase = 1;
        end else if (submit || (tick && m_time == 1)) begin
          if (!submit) m_time = 0;
          m_wp     = 1;
          m_streak = 0;
          m_lives--;
          m_phase  = (m_lives == 0) ? 3 : 1;
        end else if (tick) begin
          m_time--;
        end
      end
    endcase
    m_go = (m_phase == 3) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("state",         32'(state),         32'(m_phase));
    chk("target",        32'(target),        32'(m_target));
    chk("time_left",     32'(time_left),     32'(m_time));
    chk("score",         32'(score),         32'(m_score));
    chk("lives",         32'(lives),         32'(m_lives));
    chk("correct_pulse", 32'(correct_pulse), 32'(m_cp));
    chk("wrong_pulse",   32'(wrong_pulse),   32'(m_wp));
    chk("game_over",     32'(game_over),     32'(m_go));
    chk("pulse_excl",    32'(correct_pulse & wrong_pulse), 32'd0);
  endtask

  task automatic step(input logic r, input logic s, input logic sub, input logic t,
                      input logic [WIDTH-1:0] v);
    rst = r; start = s; submit = sub; tick = t; sw = v;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  logic             r_r, r_s, r_sub, r_t;
  logic [WIDTH-1:0] r_v;

  initial begin
    rst = 1'b1; start = 1'b0; submit = 1'b0; tick = 1'b0; sw = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_time",  32'(time_left), 32'd10);
    idle(3);

    // first round: correct answer
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    chk("target_nonzero", 32'(target != '0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(m_target));
    chk("correct_seen", 32'(correct_pulse), 32'd1);
    chk("score_one", 32'(score), 32'd1);
    idle(2);
    chk("time_reload", 32'(time_left), 32'd10);

    // three wrong answers end the game
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(m_target) ^ WIDTH'(1));
      chk("wrong_seen", 32'(wrong_pulse), 32'd1);
      idle(2);
    end
    chk("over_state", 32'(state), 32'd3);
    chk("over_flag",  32'(game_over), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("over_lives", 32'(lives), 32'd0);

    // restart from OVER, then let the countdown expire
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      idle(1);
    end
    chk("time_one", 32'(time_left), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("timeout_pulse", 32'(wrong_pulse), 32'd1);
    chk("timeout_lives", 32'(lives), 32'd2);
    idle(2);
    chk("timeout_reload", 32'(time_left), 32'd10);

    // correct submit coincident with the final tick
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, 1'b1, WIDTH'(m_target));
    chk("tie_correct", 32'(correct_pulse), 32'd1);
    chk("tie_lives",   32'(lives), 32'd2);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("midplay_rst", 32'(state), 32'd0);

    // streak run: four correct, one wrong, three correct
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(m_target) ^ WIDTH'(2));
      else        step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'(m_target));
      idle(2);
    end

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      r_r   = ($urandom_range(0, 499) == 0);
      r_s   = ($urandom_range(0, 15) == 0);
      r_sub = ($urandom_range(0, 5) == 0);
      r_t   = ($urandom_range(0, 3) == 0);
      r_v   = ($urandom_range(0, 1) == 1) ? WIDTH'(m_target) : WIDTH'($urandom);
      step(r_r, r_s, r_sub, r_t, r_v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
